base_emux_stream: RTL and testbench
===================================

# base_emux_stream

Stream-steered successor of the encoded mux: a select stream of encoded way numbers steers beats (or whole packets) from one of `ways` valid/ready input channels onto a single registered valid/ready output. Used wherever an ordered schedule of source indices must merge several streams into one without combinational paths from output backpressure to input ready. Output is buffered by a 2-entry skid buffer so `o_d`/`o_v` come straight from flops.

## Interface
- `width`, 1, data bits per beat.
- `ways`, 2, number of input channels (>=2).
- `sel_width`, `$clog2(ways)`, encoded select width.
- `pkt`, 0, 0 = one beat per select token; 1 = select held until a beat with `i_e`=1 on the selected way.

- `clk`  in  1  clock, all flops rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_v`  in  1  select token valid.
- `s_r`  out  1  select token accepted when `s_v & s_r`.
- `s_d`  in  [0:sel_width-1]  encoded way number.
- `i_v`  in  [0:ways-1]  per-way input valid.
- `i_r`  out  [0:ways-1]  per-way input ready.
- `i_d`  in  [0:width*ways-1]  way k at bits [k*width : k*width+width-1].
- `i_e`  in  [0:ways-1]  per-way end-of-packet marker (ignored when `pkt`=0).
- `o_v`  out  1  output valid.
- `o_r`  in  1  output ready.
- `o_d`  out  [0:width-1]  output data.
- `o_e`  out  1  end marker travelling with `o_d` (always 1 when `pkt`=0).
- `o_err`  out  1  one-cycle pulse: token with `s_d >= ways` consumed.

## Operation
- FSM states IDLE, ACTIVE; registered `cur` holds the accepted way.
- Beat transfer `xfer = ACTIVE & i_v[cur] & i_r[cur]`; `last = xfer & (pkt==0 | i_e[cur])`.
- `s_r = IDLE | last` (same-cycle token replacement on the last beat; `s_r` may depend combinationally on `i_v`/`i_e`).
- Token accept with `s_d < ways`: `cur <= s_d`, state ACTIVE. With `s_d >= ways`: token dropped, `o_err` pulses next cycle, state IDLE (or IDLE after `last`).
- Token not accepted on `last`: ACTIVE -> IDLE.
- `i_r[k] = ACTIVE & (k==cur) & ~full`; all other ways 0. `i_r` never depends on `o_r` combinationally.
- Skid buffer: 2 entries of {data, end}; `full` = count==2 (registered). Write on `xfer`; read on `o_v & o_r`; simultaneous read/write keeps count. `o_v = count!=0`, `o_d/o_e` = head entry.
- Beats from one way emerge in input order; packets never interleave.
- Non-selected `i_v` are ignored and never consumed.

## Timing
- Reset (async assert, sync-safe release): state IDLE, `cur`=0, count=0, `o_v`=0, `o_d`=0, `o_e`=0, `o_err`=0; `s_r`=1 in first cycle after release; all `i_r`=0.
- Token accepted cycle t -> earliest input beat cycle t+1 -> `o_v` cycle t+2.
- Throughput 1 beat/cycle sustained, including across back-to-back single-beat tokens (`pkt`=0) when `o_r`=1.
- `o_r`=0 held: at most 2 beats absorbed, then `i_r[cur]`=0 from the cycle after count reaches 2.
- Reset mid-packet: buffered and partial-packet data discarded; no output beat after reset until a new token.
- `s_v` with no token pending and `i_v[cur]` never asserting: block stalls in ACTIVE indefinitely (no timeout).

## Test plan
- `ways`=4, `width`=8, `pkt`=0: tokens 2,0,3 back-to-back, ways hold 0xA0/0xB0/0xC0/0xD0, `o_r`=1 -> `o_d` = 0xC0,0xA0,0xD0 on consecutive cycles starting 2 cycles after first token.
- `pkt`=1: token 1, way 1 sends 0x11,0x12,0x13(`i_e`=1) while way 0 `i_v`=1 -> output 0x11,0x12,0x13, `o_e` only on 0x13; `i_r[0]` stays 0 throughout.
- Backpressure: `o_r`=0 for 5 cycles during a 4-beat packet -> exactly 2 beats accepted, `i_r[cur]`=0 afterwards; release `o_r` -> all 4 beats out in order, none duplicated.
- `ways`=3, token `s_d`=3 -> `o_err`=1 for exactly one cycle, no `i_r` asserted, next token 1 serviced normally.
- `reset_n` low mid-packet with 2 beats buffered -> `o_v`=0, `o_d`=0, `s_r`=1 after release; next token yields only new data.

Source files
------------

// File: rtl/base_emux_stream.sv
// base_emux_stream: a stream of encoded way numbers steers beats (pkt=0) or
// whole packets (pkt=1) from one of `ways` valid/ready inputs onto a single
// output. The output sits behind a 2-entry skid buffer, so o_v/o_d/o_e come
// straight from flops and i_r never depends combinationally on o_r.
module base_emux_stream #(
   parameter int width     = 1,
   parameter int ways      = 2,
   parameter int sel_width = $clog2(ways),
   parameter bit pkt       = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   s_v,
   output logic                   s_r,
   input  logic [0:sel_width-1]   s_d,
   input  logic [0:ways-1]        i_v,
   output logic [0:ways-1]        i_r,
   input  logic [0:width*ways-1]  i_d,
   input  logic [0:ways-1]        i_e,
   output logic                   o_v,
   input  logic                   o_r,
   output logic [0:width-1]       o_d,
   output logic                   o_e,
   output logic                   o_err
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACTIVE = 1'b1;

   // One extra bit so a token equal to `ways` still compares correctly.
   localparam logic [sel_width:0] ways_lim = (sel_width + 1)'(ways);

   logic [0:0]           state;
   logic [sel_width-1:0] cur;
   logic [1:0]           count;
   logic [width-1:0]     buf_d [2];
   logic                 buf_e [2];

   logic                 active;
   logic                 full;
   logic                 sel_v;
   logic                 sel_e;
   logic [width-1:0]     sel_d;
   logic                 wr_e;
   logic                 xfer;
   logic                 last;
   logic                 tok_acc;
   logic                 tok_ok;
   logic                 rd;

   assign active  = (state == ACTIVE);
   assign full    = (count == 2'd2);
   assign xfer    = active & sel_v & ~full;
   assign last    = xfer & ((pkt == 1'b0) | sel_e);
   assign s_r     = ~active | last;
   assign tok_acc = s_v & s_r;
   assign tok_ok  = ({1'b0, s_d} < ways_lim);
   assign wr_e    = (pkt == 1'b0) ? 1'b1 : sel_e;
   assign rd      = o_v & o_r;

   assign o_v = (count != 2'd0);
   assign o_d = buf_d[0];
   assign o_e = buf_e[0];

   // Pick valid, end marker and data of the currently steered way.
   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      sel_v = 1'b0;
      sel_e = 1'b0;
      sel_d = '0;
      for (int k = 0; k < ways; k++) begin
         if (cur == sel_width'(k)) begin
            sel_v = i_v[k];
            sel_e = i_e[k];
            sel_d = i_d[k*width +: width];
         end
      end
   end

   // Only the steered way sees ready, and only while the buffer has room.
   always_comb begin
      i_r = '0;
      for (int k = 0; k < ways; k++) begin
         i_r[k] = active & (cur == sel_width'(k)) & ~full;
      end
   end

   // Token FSM: accept a way number, stay ACTIVE until its last beat.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      if (!reset_n) begin
         state <= IDLE;
         cur   <= '0;
         o_err <= 1'b0;
      end else begin
         o_err <= tok_acc & ~tok_ok;
         if (tok_acc && tok_ok) begin
            state <= ACTIVE;
            cur   <= s_d;
         end else if (tok_acc || last) begin
            state <= IDLE;
         end
      end
   end

   // Two-entry skid buffer; entry 0 is the head that drives the output.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: both entries are reset because entry 0 drives o_d/o_e directly
      // and must read zero after reset.
      if (!reset_n) begin
         count    <= 2'd0;
         buf_d[0] <= '0;
         buf_d[1] <= '0;
         buf_e[0] <= 1'b0;
         buf_e[1] <= 1'b0;
      end else begin
         case (count)
            2'd0: begin
               if (xfer) begin
                  buf_d[0] <= sel_d;
                  buf_e[0] <= wr_e;
                  count    <= 2'd1;
               end
            end
            2'd1: begin
               if (xfer && rd) begin
                  buf_d[0] <= sel_d;
                  buf_e[0] <= wr_e;
               end else if (xfer) begin
                  buf_d[1] <= sel_d;
                  buf_e[1] <= wr_e;
                  count    <= 2'd2;
               end else if (rd) begin
                  count    <= 2'd0;
               end
            end
            default: begin
               if (rd) begin
                  buf_d[0] <= buf_d[1];
                  buf_e[0] <= buf_e[1];
                  count    <= 2'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_base_emux_stream.sv
// Bench for base_emux_stream: a cycle table on a 4-way beat-mode instance,
// directed packet sequences and a randomized run on a 3-way packet-mode
// instance checked against a queue-based model of the merged stream.
module tb_base_emux_stream;

   typedef struct packed {
      logic [7:0] d;
      logic       e;
   } beat_t;

   typedef struct {
      logic       sv;
      int         sd;
      logic       orr;
      logic       sr;
      int         rdy;
      logic       ov;
      logic [7:0] od;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Instance A: ways=4, width=8, pkt=0
   logic        a_sv = 1'b0;
   logic        a_sr;
   logic [0:1]  a_sd = '0;
   logic [0:3]  a_iv = '0;
   logic [0:3]  a_ir;
   logic [0:31] a_id = '0;
   logic [0:3]  a_ie = '0;
   logic        a_ov;
   logic        a_or = 1'b0;
   logic [0:7]  a_od;
   logic        a_oe;
   logic        a_oerr;

   // Instance B: ways=3, width=8, pkt=1
   logic        b_sv = 1'b0;
   logic        b_sr;
   logic [0:1]  b_sd = '0;
   logic [0:2]  b_iv = '0;
   logic [0:2]  b_ir;
   logic [0:23] b_id = '0;
   logic [0:2]  b_ie = '0;
   logic        b_ov;
   logic        b_or = 1'b0;
   logic [0:7]  b_od;
   logic        b_oe;
   logic        b_oerr;

   base_emux_stream #(.width(8), .ways(4), .pkt(1'b0)) dut_a (
      .clk(clk), .reset_n(reset_n),
      .s_v(a_sv), .s_r(a_sr), .s_d(a_sd),
      .i_v(a_iv), .i_r(a_ir), .i_d(a_id), .i_e(a_ie),
      .o_v(a_ov), .o_r(a_or), .o_d(a_od), .o_e(a_oe), .o_err(a_oerr)
   );

   base_emux_stream #(.width(8), .ways(3), .pkt(1'b1)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .s_v(b_sv), .s_r(b_sr), .s_d(b_sd),
      .i_v(b_iv), .i_r(b_ir), .i_d(b_id), .i_e(b_ie),
      .o_v(b_ov), .o_r(b_or), .o_d(b_od), .o_e(b_oe), .o_err(b_oerr)
   );

   // Model of instance B: pending tokens, per-way source beats, and the
   // merged output stream those tokens imply.
   int    tok_q[$];
   beat_t src_q[3][$];
   beat_t exp_q[$];
   int    exp_err  = 0;
   int    got_err  = 0;
   logic  err_pend = 1'b0;
   int    p_sv = 100;
   int    p_iv = 100;
   int    p_or = 100;
   bit    junk0 = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_beat(input int way, input logic [7:0] d, input logic e);
      beat_t b;
      b.d = d;
      b.e = e;
      src_q[way].push_back(b);
      exp_q.push_back(b);
   endtask

   task automatic push_tok(input int way);
      tok_q.push_back(way);
      if (way >= 3) exp_err++;
   endtask

   function automatic bit busy_b();
      return (tok_q.size() != 0) || (exp_q.size() != 0) ||
             (src_q[0].size() != 0) || (src_q[1].size() != 0) || (src_q[2].size() != 0);
   endfunction

   function automatic int ready_way_a();
      int w = -1;
      for (int k = 0; k < 4; k++) begin
         if (a_ir[k]) w = (w == -1) ? k : -2;
      end
      return w;
   endfunction

   // One cycle on instance B: drive from the model at posedge+1, observe
   // handshakes at the negedge, update the model, return at posedge+1.
   task automatic step_b();
      beat_t h;
      b_sv = (tok_q.size() > 0) && ($urandom_range(99) < p_sv);
      b_sd = (tok_q.size() > 0) ? 2'(tok_q[0]) : 2'd0;
      for (int k = 0; k < 3; k++) begin
         if (src_q[k].size() > 0 && $urandom_range(99) < p_iv) begin
            b_iv[k]         = 1'b1;
            b_id[k*8 +: 8]  = src_q[k][0].d;
            b_ie[k]         = src_q[k][0].e;
         end else if (junk0 && k == 0) begin
            b_iv[k]         = 1'b1;
            b_id[k*8 +: 8]  = 8'h55;
            b_ie[k]         = 1'b1;
         end else begin
            b_iv[k]         = 1'b0;
            b_id[k*8 +: 8]  = 8'($urandom);
            b_ie[k]         = 1'($urandom);
         end
      end
      b_or = ($urandom_range(99) < p_or);
      @(negedge clk);
      check("ir_onehot", 32'($countones(b_ir) <= 1), 32'd1);
      check("o_err", 32'(b_oerr), 32'(err_pend));
      if (b_oerr) got_err++;
      err_pend = 1'b0;
      if (b_sv && b_sr) begin
         if (tok_q[0] >= 3) err_pend = 1'b1;
         void'(tok_q.pop_front());
      end
      for (int k = 0; k < 3; k++) begin
         if (b_iv[k] && b_ir[k]) begin
            if (src_q[k].size() == 0) begin
               total++;
               bad++;
               $display("FAIL in_unowned: way %0d consumed data %0h expected no transfer", k, b_id[k*8 +: 8]);
            end else begin
               void'(src_q[k].pop_front());
            end
         end
      end
      if (b_ov && b_or) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out_extra: got %0h expected no beat", b_od);
         end else begin
            h = exp_q.pop_front();
            check("out_beat", 32'({b_od, b_oe}), 32'(h));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_b(input string name, input int max_cycles);
      int n = 0;
      while (busy_b() && n < max_cycles) begin
         step_b();
         n++;
      end
      check({name, "_drained"}, 32'(busy_b()), 32'd0);
      repeat (4) step_b();
      check({name, "_idle_ov"}, 32'(b_ov), 32'd0);
   endtask

   vec_t vt[16];

   initial begin
      // sv sd or | sr rdy ov od
      vt[0]  = '{1'b1, 2, 1'b1, 1'b1, -1, 1'b0, 8'h00};
      vt[1]  = '{1'b1, 0, 1'b1, 1'b1,  2, 1'b0, 8'h00};
      vt[2]  = '{1'b1, 3, 1'b1, 1'b1,  0, 1'b1, 8'hC0};
      vt[3]  = '{1'b0, 0, 1'b1, 1'b1,  3, 1'b1, 8'hA0};
      vt[4]  = '{1'b0, 0, 1'b1, 1'b1, -1, 1'b1, 8'hD0};
      vt[5]  = '{1'b0, 0, 1'b1, 1'b1, -1, 1'b0, 8'h00};
      vt[6]  = '{1'b1, 1, 1'b0, 1'b1, -1, 1'b0, 8'h00};
      vt[7]  = '{1'b0, 0, 1'b0, 1'b1,  1, 1'b0, 8'h00};
      vt[8]  = '{1'b1, 1, 1'b0, 1'b1, -1, 1'b1, 8'hB0};
      vt[9]  = '{1'b0, 0, 1'b0, 1'b1,  1, 1'b1, 8'hB0};
      vt[10] = '{1'b1, 2, 1'b0, 1'b1, -1, 1'b1, 8'hB0};
      vt[11] = '{1'b0, 0, 1'b0, 1'b0, -1, 1'b1, 8'hB0};
      vt[12] = '{1'b0, 0, 1'b1, 1'b0, -1, 1'b1, 8'hB0};
      vt[13] = '{1'b0, 0, 1'b1, 1'b1,  2, 1'b1, 8'hB0};
      vt[14] = '{1'b0, 0, 1'b1, 1'b1, -1, 1'b1, 8'hC0};
      vt[15] = '{1'b0, 0, 1'b1, 1'b1, -1, 1'b0, 8'h00};

      a_iv = 4'b1111;
      a_id = {8'hA0, 8'hB0, 8'hC0, 8'hD0};

      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_a_sr",   32'(a_sr),   32'd1);
      check("rst_a_ir",   32'(a_ir),   32'd0);
      check("rst_a_ov",   32'(a_ov),   32'd0);
      check("rst_a_od",   32'(a_od),   32'd0);
      check("rst_a_oe",   32'(a_oe),   32'd0);
      check("rst_a_oerr", 32'(a_oerr), 32'd0);
      check("rst_b_sr",   32'(b_sr),   32'd1);
      check("rst_b_ir",   32'(b_ir),   32'd0);
      check("rst_b_ov",   32'(b_ov),   32'd0);

      // Cycle table: tokens 2,0,3 back-to-back, then backpressure on A.
      for (int i = 0; i < 16; i++) begin
         a_sv = vt[i].sv;
         a_sd = 2'(vt[i].sd);
         a_or = vt[i].orr;
         @(negedge clk);
         check($sformatf("vec%0d_sr", i),   32'(a_sr),          32'(vt[i].sr));
         check($sformatf("vec%0d_rdy", i),  32'(ready_way_a()), 32'(vt[i].rdy));
         check($sformatf("vec%0d_ov", i),   32'(a_ov),          32'(vt[i].ov));
         check($sformatf("vec%0d_oerr", i), 32'(a_oerr),        32'd0);
         if (vt[i].ov) begin
            check($sformatf("vec%0d_od", i), 32'(a_od), 32'(vt[i].od));
            check($sformatf("vec%0d_oe", i), 32'(a_oe), 32'd1);
         end
         @(posedge clk);
         #1;
      end
      a_sv = 1'b0;
      a_or = 1'b1;

      // Packet steering: way 0 keeps offering data it must never give up.
      junk0 = 1'b1;
      push_beat(1, 8'h11, 1'b0);
      push_beat(1, 8'h12, 1'b0);
      push_beat(1, 8'h13, 1'b1);
      push_tok(1);
      run_b("pkt", 40);
      junk0 = 1'b0;

      // Backpressure: output stalled for 5 cycles during a 4-beat packet.
      p_or = 0;
      push_beat(2, 8'h21, 1'b0);
      push_beat(2, 8'h22, 1'b0);
      push_beat(2, 8'h23, 1'b0);
      push_beat(2, 8'h24, 1'b1);
      push_tok(2);
      repeat (5) step_b();
      check("bp_accepted",  32'(4 - src_q[2].size()), 32'd2);
      check("bp_ready_low", 32'(b_ir[2]),             32'd0);
      p_or = 100;
      run_b("bp", 40);

      // Out-of-range token on the 3-way instance, then a normal token.
      push_tok(3);
      step_b();
      check("err_no_ready", 32'(b_ir), 32'd0);
      check("err_idle_sr",  32'(b_sr), 32'd1);
      push_beat(1, 8'h31, 1'b0);
      push_beat(1, 8'h32, 1'b1);
      push_tok(1);
      run_b("err", 40);

      // Reset in the middle of a packet with two beats buffered.
      p_or = 0;
      push_beat(0, 8'h41, 1'b0);
      push_beat(0, 8'h42, 1'b0);
      push_beat(0, 8'h43, 1'b0);
      push_beat(0, 8'h44, 1'b1);
      push_tok(0);
      repeat (5) step_b();
      check("rst_buffered", 32'(4 - src_q[0].size()), 32'd2);
      reset_n = 1'b0;
      #1;
      check("rst_mid_ov", 32'(b_ov), 32'd0);
      check("rst_mid_od", 32'(b_od), 32'd0);
      check("rst_mid_oe", 32'(b_oe), 32'd0);
      tok_q.delete();
      exp_q.delete();
      for (int k = 0; k < 3; k++) src_q[k].delete();
      err_pend = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_rel_sr", 32'(b_sr), 32'd1);
      check("rst_rel_ir", 32'(b_ir), 32'd0);
      check("rst_rel_ov", 32'(b_ov), 32'd0);
      p_or = 100;
      push_beat(0, 8'h61, 1'b0);
      push_beat(0, 8'h62, 1'b1);
      push_tok(0);
      run_b("rst_new", 40);

      // Randomized merge of packets from all ways, with stray bad tokens.
      p_sv = 70;
      p_iv = 70;
      p_or = 60;
      for (int t = 0; t < 60; t++) begin
         int way;
         int len;
         way = ($urandom_range(9) == 0) ? 3 : int'($urandom_range(2));
         if (way < 3) begin
            len = int'($urandom_range(4, 1));
            for (int j = 0; j < len; j++) begin
               push_beat(way, 8'($urandom), (j == len - 1));
            end
         end
         push_tok(way);
      end
      run_b("rand", 5000);
      check("err_count", 32'(got_err), 32'(exp_err));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
